// File: rtl/hilo_muldiv_pkg.sv
// Shared EXE op-code defines plus the FSM and accumulate-mode types of the HI/LO unit.
`ifndef EXE_OP_DEFINES
`define EXE_OP_DEFINES
`define EXE_NOP_OP    8'b00000000
`define EXE_MFHI_OP   8'b00010000
`define EXE_MTHI_OP   8'b00010001
`define EXE_MFLO_OP   8'b00010010
`define EXE_MTLO_OP   8'b00010011
`define EXE_MULT_OP   8'b00011000
`define EXE_MULTU_OP  8'b00011001
`define EXE_DIV_OP    8'b00011010
`define EXE_DIVU_OP   8'b00011011
`define EXE_MADD_OP   8'b10100110
`define EXE_MADDU_OP  8'b10101000
`define EXE_MSUB_OP   8'b10101010
`define EXE_MSUBU_OP  8'b10101011
`endif

package hilo_muldiv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } state_t;

   // How the registered product is folded into HI:LO.
   typedef enum logic [1:0] {
      ACC_SET = 2'd0,
      ACC_ADD = 2'd1,
      ACC_SUB = 2'd2
   } acc_t;

endpackage

// File: rtl/hilo_muldiv_div_iter.sv
// Restoring divider: one quotient bit per cycle, sign fix-up and divide-by-zero override on the last step.
module div_iter
   import hilo_muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             cancel,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic          running;
   logic [CW-1:0] count;

   logic [WIDTH-1:0] rem_p0, quo_p0, dsr_p0, dvd_p0;
   logic             neg_q_p0, neg_r_p0, dz_p0;

   logic [WIDTH:0]   trial, diff;
   logic             take;
   logic [WIDTH-1:0] rem_nx, quo_nx;

   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   always_comb begin
      trial  = {rem_p0, quo_p0[WIDTH-1]};
      diff   = trial - {1'b0, dsr_p0};
      take   = ~diff[WIDTH];
      rem_nx = take ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
      quo_nx = {quo_p0[WIDTH-2:0], take};
   end

   assign done      = running && (count == LAST);
   assign quotient  = dz_p0 ? '1 : cond_neg(quo_nx, neg_q_p0);
   assign remainder = dz_p0 ? dvd_p0 : cond_neg(rem_nx, neg_r_p0);

   always_ff @(posedge clk) begin
      if (rst) begin
         running <= 1'b0;
         count   <= '0;
      end else if (start) begin
         running <= 1'b1;
         count   <= '0;
      end else if (cancel || done) begin
         running <= 1'b0;
      end else if (running) begin
         count <= count + 1'b1;
      end
   end

   // Operands are latched as magnitudes; signs are reapplied after the last step.
   always_ff @(posedge clk) begin
      if (start) begin
         rem_p0   <= '0;
         quo_p0   <= cond_neg(dividend, is_signed & dividend[WIDTH-1]);
         dsr_p0   <= cond_neg(divisor, is_signed & divisor[WIDTH-1]);
         neg_q_p0 <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
         neg_r_p0 <= is_signed & dividend[WIDTH-1];
         dz_p0    <= (divisor == '0);
         dvd_p0   <= dividend;
      end else if (running) begin
         rem_p0 <= rem_nx;
         quo_p0 <= quo_nx;
      end
   end

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO unit: single-cycle multiply/accumulate, iterative divide, MTHI/MTLO writes and MFHI/MFLO reads.
module hilo_muldiv
   import hilo_muldiv_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int HAS_MADD = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid,
   input  logic [7:0]       alucontrol,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             cancel,
   output logic             busy,
   output logic             result_ok,
   output logic [WIDTH-1:0] hilo_out
);
   localparam int PW      = 2 * WIDTH;
   localparam bit MADD_EN = (HAS_MADD != 0);

   state_t           state;
   logic [WIDTH-1:0] hi, lo;

   logic signed [PW-1:0] prod_p0;
   acc_t                 acc_p0;

   logic                 accept, is_mul, is_div, mul_signed, div_signed;
   acc_t                 acc_sel;
   logic signed [PW-1:0] op_a, op_b, prod;
   logic [PW-1:0]        hilo_next;
   logic                 div_start, div_done;
   logic [WIDTH-1:0]     quo, rem;

   assign busy   = (state != IDLE);
   assign accept = valid && !busy && !cancel && !rst;

   always_comb begin
      is_mul     = 1'b0;
      is_div     = 1'b0;
      mul_signed = 1'b0;
      div_signed = 1'b0;
      acc_sel    = ACC_SET;
      case (alucontrol)
         `EXE_MULT_OP:  begin is_mul = 1'b1; mul_signed = 1'b1; end
         `EXE_MULTU_OP: is_mul = 1'b1;
         `EXE_MADD_OP:  begin is_mul = MADD_EN; mul_signed = 1'b1; acc_sel = ACC_ADD; end
         `EXE_MADDU_OP: begin is_mul = MADD_EN; acc_sel = ACC_ADD; end
         `EXE_MSUB_OP:  begin is_mul = MADD_EN; mul_signed = 1'b1; acc_sel = ACC_SUB; end
         `EXE_MSUBU_OP: begin is_mul = MADD_EN; acc_sel = ACC_SUB; end
         `EXE_DIV_OP:   begin is_div = 1'b1; div_signed = 1'b1; end
         `EXE_DIVU_OP:  is_div = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      op_a = {{WIDTH{mul_signed & rs_val[WIDTH-1]}}, rs_val};
      op_b = {{WIDTH{mul_signed & rt_val[WIDTH-1]}}, rt_val};
      prod = op_a * op_b;
   end

   always_comb begin
      case (acc_p0)
         ACC_ADD: hilo_next = {hi, lo} + prod_p0;
         ACC_SUB: hilo_next = {hi, lo} - prod_p0;
         default: hilo_next = prod_p0;
      endcase
   end

   assign div_start = accept && is_div;

   div_iter #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .is_signed (div_signed),
      .dividend  (rs_val),
      .divisor   (rt_val),
      .cancel    (cancel),
      .done      (div_done),
      .quotient  (quo),
      .remainder (rem)
   );

   // A cancel or reset in the completing cycle suppresses both the pulse and the write.
   assign result_ok = !cancel && !rst && ((state == MUL) || (state == DIV && div_done));

   always_comb begin
      hilo_out = '0;
      if (valid && alucontrol == `EXE_MFHI_OP) hilo_out = hi;
      else if (valid && alucontrol == `EXE_MFLO_OP) hilo_out = lo;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         hi    <= '0;
         lo    <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               if (is_mul) state <= MUL;
               else if (is_div) state <= DIV;
               if (alucontrol == `EXE_MTHI_OP) hi <= rs_val;
               if (alucontrol == `EXE_MTLO_OP) lo <= rs_val;
            end
            MUL: begin
               state <= IDLE;
               if (!cancel) {hi, lo} <= hilo_next;
            end
            DIV: begin
               if (cancel) begin
                  state <= IDLE;
               end else if (div_done) begin
                  state <= IDLE;
                  hi    <= rem;
                  lo    <= quo;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Product stage: captured in the accept cycle, consumed in the MUL cycle.
   always_ff @(posedge clk) begin
      if (accept) begin
         prod_p0 <= prod;
         acc_p0  <= acc_sel;
      end
   end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Bench for hilo_muldiv: directed corner cases then random ops against an arithmetic HI/LO model.
module tb_hilo_muldiv;

   logic        clk;
   logic        rst;
   logic        valid;
   logic [7:0]  alucontrol;
   logic [31:0] rs_val, rt_val;
   logic        cancel;
   logic        busy, result_ok;
   logic [31:0] hilo_out;
   logic        busy0, result_ok0;
   logic [31:0] z_out;

   int nchk = 0;
   int nerr = 0;

   logic [31:0] m_hi, m_lo, z_hi, z_lo;

   logic [7:0] ops [12] = '{`EXE_MULT_OP, `EXE_MULTU_OP, `EXE_MADD_OP, `EXE_MADDU_OP,
                            `EXE_MSUB_OP, `EXE_MSUBU_OP, `EXE_DIV_OP, `EXE_DIVU_OP,
                            `EXE_MTHI_OP, `EXE_MTLO_OP, `EXE_DIV_OP, `EXE_MULT_OP};

   hilo_muldiv #(.WIDTH(32), .HAS_MADD(1)) dut (
      .clk(clk), .rst(rst), .valid(valid), .alucontrol(alucontrol),
      .rs_val(rs_val), .rt_val(rt_val), .cancel(cancel),
      .busy(busy), .result_ok(result_ok), .hilo_out(hilo_out)
   );

   hilo_muldiv #(.WIDTH(32), .HAS_MADD(0)) dut0 (
      .clk(clk), .rst(rst), .valid(valid), .alucontrol(alucontrol),
      .rs_val(rs_val), .rt_val(rt_val), .cancel(cancel),
      .busy(busy0), .result_ok(result_ok0), .hilo_out(z_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic div_ref(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r);
      int sa, sb;
      if (b == 32'h0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (sgn) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'h0;
         end else begin
            sa = a;
            sb = b;
            q  = sa / sb;
            r  = sa % sb;
         end
      end else begin
         q = a / b;
         r = a % b;
      end
   endtask

   task automatic model_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      la, lb;
      logic [63:0] sp, up, acc;
      la  = longint'($signed(a));
      lb  = longint'($signed(b));
      sp  = la * lb;
      up  = {32'h0, a} * {32'h0, b};
      acc = {m_hi, m_lo};
      case (op)
         `EXE_MULT_OP:  begin {m_hi, m_lo} = sp; {z_hi, z_lo} = sp; end
         `EXE_MULTU_OP: begin {m_hi, m_lo} = up; {z_hi, z_lo} = up; end
         `EXE_MADD_OP:  {m_hi, m_lo} = acc + sp;
         `EXE_MADDU_OP: {m_hi, m_lo} = acc + up;
         `EXE_MSUB_OP:  {m_hi, m_lo} = acc - sp;
         `EXE_MSUBU_OP: {m_hi, m_lo} = acc - up;
         `EXE_DIV_OP:   begin div_ref(1'b1, a, b, m_lo, m_hi); z_lo = m_lo; z_hi = m_hi; end
         `EXE_DIVU_OP:  begin div_ref(1'b0, a, b, m_lo, m_hi); z_lo = m_lo; z_hi = m_hi; end
         `EXE_MTHI_OP:  begin m_hi = a; z_hi = a; end
         `EXE_MTLO_OP:  begin m_lo = a; z_lo = a; end
         default: ;
      endcase
   endtask

   task automatic read_pair(input string tag, input logic [31:0] ehi, input logic [31:0] elo,
                            input logic [31:0] zhi, input logic [31:0] zlo);
      valid = 1'b1; alucontrol = `EXE_MFHI_OP; #1;
      check({tag, ".hi"}, hilo_out, ehi);
      check({tag, ".z_hi"}, z_out, zhi);
      alucontrol = `EXE_MFLO_OP; #1;
      check({tag, ".lo"}, hilo_out, elo);
      check({tag, ".z_lo"}, z_out, zlo);
      valid = 1'b0; alucontrol = `EXE_NOP_OP;
      tick();
   endtask

   task automatic run_op(input string tag, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b);
      int nbusy, okcnt, okat, expn;
      bit madd_cls;
      madd_cls = op inside {`EXE_MADD_OP, `EXE_MADDU_OP, `EXE_MSUB_OP, `EXE_MSUBU_OP};
      expn = (op inside {`EXE_DIV_OP, `EXE_DIVU_OP}) ? 32 :
             (madd_cls || op inside {`EXE_MULT_OP, `EXE_MULTU_OP}) ? 1 : 0;
      valid = 1'b1; alucontrol = op; rs_val = a; rt_val = b; #1;
      check({tag, ".acc_busy"}, 32'(busy), 32'h0);
      check({tag, ".acc_out"}, hilo_out, 32'h0);
      tick();
      valid = 1'b0; alucontrol = `EXE_NOP_OP; #1;
      check({tag, ".z_busy"}, 32'(busy0), (madd_cls || expn == 0) ? 32'h0 : 32'h1);
      nbusy = 0; okcnt = 0; okat = 0;
      while (busy && nbusy < 64) begin
         nbusy++;
         if (result_ok) begin okcnt++; okat = nbusy; end
         tick(); #1;
      end
      check({tag, ".busy_cycles"}, nbusy, expn);
      check({tag, ".ok_count"}, okcnt, (expn != 0) ? 32'h1 : 32'h0);
      check({tag, ".ok_cycle"}, okat, expn);
      model_op(op, a, b);
      read_pair(tag, m_hi, m_lo, z_hi, z_lo);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return $urandom_range(1, 20);
         default: return $urandom();
      endcase
   endfunction

   initial begin
      rst = 1'b1; valid = 1'b0; cancel = 1'b0;
      alucontrol = `EXE_NOP_OP; rs_val = '0; rt_val = '0;
      m_hi = '0; m_lo = '0; z_hi = '0; z_lo = '0;
      repeat (2) tick();
      rst = 1'b0; #1;
      check("rst.busy", 32'(busy), 32'h0);
      check("rst.result_ok", 32'(result_ok), 32'h0);
      read_pair("rst", 32'h0, 32'h0, 32'h0, 32'h0);

      run_op("mult", `EXE_MULT_OP, 32'hFFFF_FFFF, 32'h2);
      read_pair("mult.lit", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run_op("multu", `EXE_MULTU_OP, 32'hFFFF_FFFF, 32'h2);
      read_pair("multu.lit", 32'h1, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFE);
      run_op("div", `EXE_DIV_OP, 32'hFFFF_FFF9, 32'h2);
      read_pair("div.lit", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu0", `EXE_DIVU_OP, 32'h5, 32'h0);
      read_pair("divu0.lit", 32'h5, 32'hFFFF_FFFF, 32'h5, 32'hFFFF_FFFF);
      run_op("divovf", `EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF);
      read_pair("divovf.lit", 32'h0, 32'h8000_0000, 32'h0, 32'h8000_0000);

      run_op("mthi", `EXE_MTHI_OP, 32'h1234_5678, 32'h0);
      read_pair("mthi.lit", 32'h1234_5678, 32'h8000_0000, 32'h1234_5678, 32'h8000_0000);

      run_op("mtlo", `EXE_MTLO_OP, 32'hFFFF_FFFF, 32'h0);
      run_op("mthi0", `EXE_MTHI_OP, 32'h0, 32'h0);
      run_op("madd", `EXE_MADD_OP, 32'h1, 32'h1);
      read_pair("madd.lit", 32'h1, 32'h0, 32'h0, 32'hFFFF_FFFF);

      // Cancel a divide at N+10, then issue a multiply in N+11.
      valid = 1'b1; alucontrol = `EXE_DIV_OP; rs_val = 32'd100; rt_val = 32'd7; #1;
      tick();
      valid = 1'b0; alucontrol = `EXE_NOP_OP; #1;
      for (int k = 1; k <= 9; k++) begin
         check($sformatf("cxl.busy%0d", k), 32'(busy), 32'h1);
         check($sformatf("cxl.ok%0d", k), 32'(result_ok), 32'h0);
         tick(); #1;
      end
      cancel = 1'b1; #1;
      check("cxl.busy10", 32'(busy), 32'h1);
      check("cxl.ok10", 32'(result_ok), 32'h0);
      tick();
      cancel = 1'b0; #1;
      check("cxl.busy11", 32'(busy), 32'h0);
      run_op("cxl.mult", `EXE_MULT_OP, 32'd3, 32'hFFFF_FFFB);

      // Reset in the middle of a divide.
      valid = 1'b1; alucontrol = `EXE_DIVU_OP; rs_val = 32'd1000; rt_val = 32'd3; #1;
      tick();
      valid = 1'b0; alucontrol = `EXE_NOP_OP;
      repeat (5) tick();
      rst = 1'b1; #1;
      tick();
      rst = 1'b0; #1;
      check("rstdiv.busy", 32'(busy), 32'h0);
      check("rstdiv.result_ok", 32'(result_ok), 32'h0);
      m_hi = '0; m_lo = '0; z_hi = '0; z_lo = '0;
      read_pair("rstdiv", 32'h0, 32'h0, 32'h0, 32'h0);

      for (int i = 0; i < 40; i++) begin
         logic [7:0]  op;
         logic [31:0] a, b;
         op = ops[$urandom_range(0, 11)];
         a  = pick();
         b  = pick();
         run_op($sformatf("rnd%0d", i), op, a, b);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
      $finish;
   end

endmodule

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width and width of each of HI and LO.
REQ-002 SHALL have parameter HAS_MADD, default 1, meaning 1 enables MADD/MADDU/MSUB/MSUBU and 0 treats those ops as no-ops.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset that is synchronous and active-high.
REQ-005 SHALL have port valid, input, 1 bit, meaning alucontrol is presented this cycle.
REQ-006 SHALL have port alucontrol, input, 8 bits, carrying an op code from the shared `EXE_*_OP defines.
REQ-007 SHALL have ports rs_val and rt_val, input, WIDTH bits each, the operands; MTHI/MTLO take data from rs_val.
REQ-008 SHALL have port cancel, input, 1 bit, the exception flush that aborts an in-flight or presented op.
REQ-009 SHALL have port busy, output, 1 bit, asserted while a mul/div is in flight; the pipeline stalls on it.
REQ-010 SHALL have port result_ok, output, 1 bit, a one-cycle pulse in the cycle HI/LO takes a mul/div result.
REQ-011 SHALL have port hilo_out, output, WIDTH bits, the MFHI/MFLO read data.

Function
REQ-012 SHALL accept an op only when valid=1, busy=0 and cancel=0 (the accept cycle, N); other ops SHALL be ignored.
REQ-013 SHALL use FSM states IDLE, MUL and DIV: IDLE->MUL on an accepted mul-class op; IDLE->DIV on an accepted DIV/DIVU; MUL->IDLE after 1 cycle; DIV->IDLE after WIDTH cycles; any state->IDLE on cancel.
REQ-014 SHALL, for MULT/MULTU, register the 2*WIDTH-bit signed/unsigned product in N, assert busy and result_ok in N+1, and write HI:LO at the end of N+1.
REQ-015 SHALL, for MADD/MADDU/MSUB/MSUBU, write HI:LO +/- product modulo 2^(2*WIDTH) with the same timing as REQ-014.
REQ-016 SHALL, for DIV/DIVU, run a one-quotient-bit-per-cycle restoring divide with busy high in N+1..N+WIDTH and result_ok in N+WIDTH; LO=quotient and HI=remainder are written at the end of N+WIDTH.
REQ-017 SHALL make signed divide truncate toward zero, with the remainder taking the dividend's sign.
REQ-018 SHALL, on divide by zero, set LO=all ones and HI=dividend; signed -2^(WIDTH-1)/-1 SHALL give LO=-2^(WIDTH-1) and HI=0.
REQ-019 SHALL make MTHI/MTLO write only the selected half at the end of N, with no busy and no result_ok.
REQ-020 SHALL drive hilo_out combinationally as the HI (MFHI) or LO (MFLO) register value when valid=1, else 0; a same-cycle write is not forwarded.
REQ-021 SHALL, when cancel=1 while busy, discard the result (no HI/LO write, no result_ok even in the final cycle) and deassert busy the next cycle.
REQ-022 SHALL keep busy at 0 in the cycle after the last busy cycle, so a new op is acceptable then.

Reset
REQ-023 SHALL, on rst=1 at a clock edge, clear HI and LO to 0, return the FSM to IDLE, and force busy=0 and result_ok=0 (so hilo_out=0) on the following cycle.
REQ-024 SHALL, on rst during MUL or DIV, abort the operation with no HI/LO write; rst SHALL take priority over cancel and valid.

Structure
REQ-025 SHALL take op codes, including any new MADD/MSUB codes, from the shared defines header and SHALL NOT hard-code them locally.
REQ-026 SHALL put the iterative divider in sub-module div_iter (start, signed, dividend, divisor, cancel -> done, quotient, remainder); the multiply, HI/LO and FSM SHALL stay in hilo_muldiv.

Verification
REQ-027 SHALL cover MULT with rs=0xFFFFFFFF, rt=0x00000002 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE; the same operands with MULTU -> HI=0x00000001, LO=0xFFFFFFFE; result_ok in N+1.
REQ-028 SHALL cover DIV with rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, busy for exactly 32 cycles, and result_ok in N+32.
REQ-029 SHALL cover DIVU with rs=5, rt=0 -> LO=0xFFFFFFFF, HI=0x00000005; and DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-030 SHALL cover MTHI rs=0x12345678 then MFHI next cycle -> hilo_out=0x12345678 with LO unchanged; MFLO in the MTLO cycle returns the old LO.
REQ-031 SHALL cover DIV with cancel at N+10 -> HI/LO unchanged, no result_ok, busy low in N+11, and a MULT accepted in N+11 completing normally.
REQ-032 SHALL cover MADD with HI:LO=0x00000000_FFFFFFFF, rs=1, rt=1 -> HI=0x00000001, LO=0x00000000; with HAS_MADD=0 the same op leaves HI:LO unchanged.
